// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD controller slice: capture FSM states,
// default geometry and the controller's command codes.
package lcd_pkg;

   localparam int AW_DEF    = 6;
   localparam int DW_DEF    = 8;
   localparam int DEPTH_DEF = 64;
   localparam int CSW_DEF   = 16;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CAPT  = 3'd1,
      CHECK = 3'd2,
      DRAIN = 3'd3,
      DONE  = 3'd4
   } cap_state_t;

   typedef enum logic [2:0] {
      WRTBK = 3'd0,
      SH_UP = 3'd1,
      SH_DN = 3'd2,
      SH_LF = 3'd3,
      SH_RT = 3'd4,
      AVG   = 3'd5,
      MRR_X = 3'd6,
      MRR_Y = 3'd7
   } lcd_cmd_t;

endpackage

// File: rtl/lcd_img_mem.sv
// Frame buffer: one synchronous write port, one combinational read port.
// Contents are intentionally not reset.
module lcd_img_mem #(
   parameter int AW = 6,
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] mem [2**AW];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/lcd_irb_capture.sv
// Captures the controller's IRB write-back burst, checks coverage, then drains
// the frame in address order over valid/ready while summing a checksum.
//
// state | meaning
// IDLE  | after reset, waiting for the first write or done
// CAPT  | accepting writes, waiting for done
// CHECK | one cycle: latch integrity flags, arm the drain
// DRAIN | streaming beats 0..DEPTH-1
// DONE  | results held; a write starts the next frame
module lcd_irb_capture
   import lcd_pkg::*;
#(
   parameter int AW    = AW_DEF,
   parameter int DW    = DW_DEF,
   parameter int DEPTH = DEPTH_DEF,
   parameter int CSW   = CSW_DEF
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           IRB_RW,
   input  logic [AW-1:0]  IRB_A,
   input  logic [DW-1:0]  IRB_D,
   input  logic           done,
   output logic           busy,
   output logic           rd_valid,
   input  logic           rd_ready,
   output logic [AW-1:0]  rd_addr,
   output logic [DW-1:0]  rd_data,
   output logic           frame_ok,
   output logic           dup_err,
   output logic           miss_err,
   output logic           late_err,
   output logic [CSW-1:0] checksum
);

   cap_state_t       state;
   logic [DEPTH-1:0] bitmap;
   logic             wr;
   logic             cap_open;
   logic             mem_we;
   logic             late_wr;
   logic             last_beat;
   logic [DW-1:0]    mem_rdata;

   assign wr        = ~IRB_RW;
   assign cap_open  = (state == IDLE) || (state == CAPT) || (state == DONE);
   assign mem_we    = wr & cap_open;
   assign late_wr   = wr & ((state == CHECK) || (state == DRAIN));
   assign last_beat = (rd_addr == AW'(DEPTH - 1));

   // Gate the read port so nothing from the unreset buffer leaks out idle.
   assign rd_data = rd_valid ? mem_rdata : '0;

   lcd_img_mem #(.AW(AW), .DW(DW)) u_mem (
      .clk   (clk),
      .we    (mem_we),
      .waddr (IRB_A),
      .wdata (IRB_D),
      .raddr (rd_addr),
      .rdata (mem_rdata)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         bitmap   <= '0;
         busy     <= 1'b0;
         rd_valid <= 1'b0;
         rd_addr  <= '0;
         frame_ok <= 1'b0;
         dup_err  <= 1'b0;
         miss_err <= 1'b0;
         late_err <= 1'b0;
         checksum <= '0;
      end else begin
         // A late write taints the frame even after its flags were latched.
         if (late_wr) begin
            late_err <= 1'b1;
            frame_ok <= 1'b0;
         end
         case (state)
            IDLE: begin
               if (wr) begin
                  bitmap[IRB_A] <= 1'b1;
                  busy          <= 1'b1;
                  state         <= CAPT;
               end else if (done) begin
                  busy  <= 1'b1;
                  state <= CHECK;
               end
            end
            CAPT: begin
               if (wr) begin
                  bitmap[IRB_A] <= 1'b1;
                  if (bitmap[IRB_A]) dup_err <= 1'b1;
               end
               if (done) state <= CHECK;
            end
            CHECK: begin
               miss_err <= ~&bitmap;
               frame_ok <= (&bitmap) & ~dup_err & ~late_err & ~late_wr;
               checksum <= '0;
               rd_addr  <= '0;
               rd_valid <= 1'b1;
               state    <= DRAIN;
            end
            DRAIN: begin
               if (rd_ready) begin
                  checksum <= checksum + {{(CSW-DW){1'b0}}, mem_rdata};
                  if (last_beat) begin
                     rd_valid <= 1'b0;
                     busy     <= 1'b0;
                     state    <= DONE;
                  end else begin
                     rd_addr <= rd_addr + 1'b1;
                  end
               end
            end
            DONE: begin
               if (wr) begin
                  bitmap   <= {{(DEPTH-1){1'b0}}, 1'b1} << IRB_A;
                  dup_err  <= 1'b0;
                  miss_err <= 1'b0;
                  late_err <= 1'b0;
                  frame_ok <= 1'b0;
                  checksum <= '0;
                  busy     <= 1'b1;
                  state    <= CAPT;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
